// File: rtl/matu_acc.sv
// matu_acc: tiled matrix-multiply accumulator.
//
// Accepts beats of an A tile (ROWS x K_TILE) and a B tile (COLS x K_TILE),
// then spends K_TILE cycles doing one multiply-accumulate per output element
// per cycle. Each add saturates. A job is one or more beats; the beat
// flagged last ends the job, and the result is held until it is consumed.
// C_WIDTH must be at least 2*IN_WIDTH.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_pre_valid    input beat valid
//   o_pre_ready    beat can be accepted (IDLE / WAIT)
//   i_pre_last     beat is the final K-tile of the job
//   i_a            A tile, element (m,k) at [(m*K_TILE+k)*IN_WIDTH +: IN_WIDTH]
//   i_b            B tile, element (n,k) at [(n*K_TILE+k)*IN_WIDTH +: IN_WIDTH]
//   i_post_ready   consumer takes the result
//   o_post_valid   result valid (DONE)
//   o_c            result, element (n,m) at [(n*ROWS+m)*C_WIDTH +: C_WIDTH]
//   o_sat          at least one add of the current job clipped
module matu_acc #(
    parameter int ROWS     = 3,
    parameter int COLS     = 1,
    parameter int K_TILE   = 9,
    parameter int IN_WIDTH = 8,
    parameter int C_WIDTH  = 16,
    parameter int SIGNED   = 0
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_pre_valid,
    output logic                               o_pre_ready,
    input  logic                               i_pre_last,
    input  logic [ROWS*K_TILE*IN_WIDTH-1:0]    i_a,
    input  logic [COLS*K_TILE*IN_WIDTH-1:0]    i_b,
    input  logic                               i_post_ready,
    output logic                               o_post_valid,
    output logic [COLS*ROWS*C_WIDTH-1:0]       o_c,
    output logic                               o_sat
);

    localparam int KW = (K_TILE > 1) ? $clog2(K_TILE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(K_TILE - 1);
    localparam logic [C_WIDTH-1:0] S_MAX = {1'b0, {(C_WIDTH-1){1'b1}}};
    localparam logic [C_WIDTH-1:0] S_MIN = {1'b1, {(C_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                             state_q, state_d;
    logic [KW-1:0]                      k_q, k_d;
    logic [ROWS*K_TILE*IN_WIDTH-1:0]    a_q, a_d;
    logic [COLS*K_TILE*IN_WIDTH-1:0]    b_q, b_d;
    logic                               last_q, last_d;
    logic [COLS*ROWS*C_WIDTH-1:0]       acc_q, acc_d;
    logic                               sat_q, sat_d;
    logic                               pre_ready_q, pre_ready_d;
    logic                               post_valid_q, post_valid_d;

    // MAC datapath intermediates
    logic [COLS*ROWS*C_WIDTH-1:0]       mac_acc;
    logic                               mac_clip;
    logic [IN_WIDTH-1:0]                a_el, b_el;
    logic [2*IN_WIDTH-1:0]              a_ext, b_ext, prod;
    logic [C_WIDTH:0]                   sum;
    logic [C_WIDTH-1:0]                 acc_el, mac_el;

    // One saturating MAC step for every (n,m) using column k_q of the tiles.
    // The sum is formed one bit wider than the accumulator so overflow can be
    // seen directly: unsigned -> carry out, signed -> top two bits disagree.
    always_comb begin
        mac_acc  = acc_q;
        mac_clip = 1'b0;
        a_el     = '0;
        b_el     = '0;
        a_ext    = '0;
        b_ext    = '0;
        prod     = '0;
        sum      = '0;
        acc_el   = '0;
        mac_el   = '0;
        for (int unsigned n = 0; n < COLS; n++) begin
            for (int unsigned m = 0; m < ROWS; m++) begin
                acc_el = acc_q[(n*ROWS+m)*C_WIDTH +: C_WIDTH];
                a_el   = a_q[(m*K_TILE + 32'(k_q))*IN_WIDTH +: IN_WIDTH];
                b_el   = b_q[(n*K_TILE + 32'(k_q))*IN_WIDTH +: IN_WIDTH];
                if (SIGNED != 0) begin
                    a_ext = {{IN_WIDTH{a_el[IN_WIDTH-1]}}, a_el};
                    b_ext = {{IN_WIDTH{b_el[IN_WIDTH-1]}}, b_el};
                    prod  = $signed(a_ext) * $signed(b_ext);
                    sum   = {{(C_WIDTH+1-2*IN_WIDTH){prod[2*IN_WIDTH-1]}}, prod}
                          + {acc_el[C_WIDTH-1], acc_el};
                    if (sum[C_WIDTH] != sum[C_WIDTH-1]) begin
                        mac_clip = 1'b1;
                        mac_el   = sum[C_WIDTH] ? S_MIN : S_MAX;
                    end else begin
                        mac_el   = sum[C_WIDTH-1:0];
                    end
                end else begin
                    a_ext = {{IN_WIDTH{1'b0}}, a_el};
                    b_ext = {{IN_WIDTH{1'b0}}, b_el};
                    prod  = a_ext * b_ext;
                    sum   = {{(C_WIDTH+1-2*IN_WIDTH){1'b0}}, prod}
                          + {1'b0, acc_el};
                    if (sum[C_WIDTH]) begin
                        mac_clip = 1'b1;
                        mac_el   = '1;
                    end else begin
                        mac_el   = sum[C_WIDTH-1:0];
                    end
                end
                mac_acc[(n*ROWS+m)*C_WIDTH +: C_WIDTH] = mac_el;
            end
        end
    end

    // Next-state and handshake logic
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        last_d  = last_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE, WAIT: begin
                if (i_pre_valid && pre_ready_q) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    last_d  = i_pre_last;
                    k_d     = '0;
                    state_d = MAC;
                    // A beat from IDLE opens a new job; from WAIT it extends one.
                    if (state_q == IDLE) begin
                        acc_d = '0;
                        sat_d = 1'b0;
                    end
                end
            end
            MAC: begin
                acc_d = mac_acc;
                sat_d = sat_q | mac_clip;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = last_q ? DONE : WAIT;
                end else begin
                    k_d     = k_q + KW'(1);
                end
            end
            DONE: begin
                if (i_post_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pre_ready_d  = (state_d == IDLE) || (state_d == WAIT);
        post_valid_d = (state_d == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            last_q       <= 1'b0;
            acc_q        <= '0;
            sat_q        <= 1'b0;
            pre_ready_q  <= 1'b1;
            post_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            a_q          <= a_d;
            b_q          <= b_d;
            last_q       <= last_d;
            acc_q        <= acc_d;
            sat_q        <= sat_d;
            pre_ready_q  <= pre_ready_d;
            post_valid_q <= post_valid_d;
        end
    end

    assign o_pre_ready  = pre_ready_q;
    assign o_post_valid = post_valid_q;
    assign o_c          = acc_q;
    assign o_sat        = sat_q;

endmodule

// File: tb/tb_matu_acc.sv
// tb_matu_acc: self-checking bench for matu_acc. An unsigned and a signed
// instance share all inputs; a saturating reference model tracks both.
module tb_matu_acc;

    localparam int ROWS     = 3;
    localparam int COLS     = 1;
    localparam int K_TILE   = 9;
    localparam int IN_WIDTH = 8;
    localparam int C_WIDTH  = 16;
    localparam int AW = ROWS*K_TILE*IN_WIDTH;
    localparam int BW = COLS*K_TILE*IN_WIDTH;
    localparam int CW = COLS*ROWS*C_WIDTH;
    localparam longint UMAX = (longint'(1) << C_WIDTH) - 1;
    localparam longint SMAX = (longint'(1) << (C_WIDTH-1)) - 1;
    localparam longint SMIN = -(longint'(1) << (C_WIDTH-1));

    logic          clk;
    logic          rst;
    logic          pre_valid;
    logic          pre_last;
    logic          post_ready;
    logic [AW-1:0] a_vec;
    logic [BW-1:0] b_vec;
    logic          pre_ready_u, post_valid_u, sat_u;
    logic          pre_ready_s, post_valid_s, sat_s;
    logic [CW-1:0] c_u, c_s;

    int errors = 0;
    int checks = 0;

    longint ref_u [COLS][ROWS];
    longint ref_s [COLS][ROWS];
    bit     rsat_u, rsat_s;
    bit     in_job;

    matu_acc #(.ROWS(ROWS), .COLS(COLS), .K_TILE(K_TILE), .IN_WIDTH(IN_WIDTH),
               .C_WIDTH(C_WIDTH), .SIGNED(0)) dut_u (
        .i_clk(clk), .i_rst(rst), .i_pre_valid(pre_valid), .o_pre_ready(pre_ready_u),
        .i_pre_last(pre_last), .i_a(a_vec), .i_b(b_vec), .i_post_ready(post_ready),
        .o_post_valid(post_valid_u), .o_c(c_u), .o_sat(sat_u)
    );

    matu_acc #(.ROWS(ROWS), .COLS(COLS), .K_TILE(K_TILE), .IN_WIDTH(IN_WIDTH),
               .C_WIDTH(C_WIDTH), .SIGNED(1)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_pre_valid(pre_valid), .o_pre_ready(pre_ready_s),
        .i_pre_last(pre_last), .i_a(a_vec), .i_b(b_vec), .i_post_ready(post_ready),
        .o_post_valid(post_valid_s), .o_c(c_s), .o_sat(sat_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_clear();
        for (int n = 0; n < COLS; n++)
            for (int m = 0; m < ROWS; m++) begin
                ref_u[n][m] = 0;
                ref_s[n][m] = 0;
            end
        rsat_u = 1'b0;
        rsat_s = 1'b0;
    endfunction

    // Every single product is added and clamped in turn, k ascending.
    function automatic void model_beat(input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic [IN_WIDTH-1:0] ae, be;
        for (int k = 0; k < K_TILE; k++)
            for (int n = 0; n < COLS; n++)
                for (int m = 0; m < ROWS; m++) begin
                    ae = a[(m*K_TILE+k)*IN_WIDTH +: IN_WIDTH];
                    be = b[(n*K_TILE+k)*IN_WIDTH +: IN_WIDTH];
                    ref_u[n][m] += longint'(ae) * longint'(be);
                    if (ref_u[n][m] > UMAX) begin
                        ref_u[n][m] = UMAX;
                        rsat_u = 1'b1;
                    end
                    ref_s[n][m] += longint'($signed(ae)) * longint'($signed(be));
                    if (ref_s[n][m] > SMAX) begin
                        ref_s[n][m] = SMAX;
                        rsat_s = 1'b1;
                    end else if (ref_s[n][m] < SMIN) begin
                        ref_s[n][m] = SMIN;
                        rsat_s = 1'b1;
                    end
                end
    endfunction

    function automatic logic [CW-1:0] exp_vec(input bit sgn);
        logic [CW-1:0] v;
        v = '0;
        for (int n = 0; n < COLS; n++)
            for (int m = 0; m < ROWS; m++)
                v[(n*ROWS+m)*C_WIDTH +: C_WIDTH] =
                    sgn ? C_WIDTH'(ref_s[n][m]) : C_WIDTH'(ref_u[n][m]);
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [IN_WIDTH-1:0] rand_el(input int mode);
        case (mode)
            0:       return IN_WIDTH'($urandom);
            1:       return IN_WIDTH'($urandom_range(0, 15));
            default: return IN_WIDTH'(int'($urandom_range(0, 31)) - 16);
        endcase
    endfunction

    function automatic logic [AW-1:0] rand_a(input int mode);
        logic [AW-1:0] r;
        for (int i = 0; i < ROWS*K_TILE; i++) r[i*IN_WIDTH +: IN_WIDTH] = rand_el(mode);
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_b(input int mode);
        logic [BW-1:0] r;
        for (int i = 0; i < COLS*K_TILE; i++) r[i*IN_WIDTH +: IN_WIDTH] = rand_el(mode);
        return r;
    endfunction

    function automatic logic [AW-1:0] dir_a();
        logic [AW-1:0] r;
        for (int m = 0; m < ROWS; m++)
            for (int k = 0; k < K_TILE; k++)
                r[(m*K_TILE+k)*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(m + k);
        return r;
    endfunction

    function automatic logic [BW-1:0] dir_b();
        logic [BW-1:0] r;
        for (int n = 0; n < COLS; n++)
            for (int k = 0; k < K_TILE; k++)
                r[(n*K_TILE+k)*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(k);
        return r;
    endfunction

    // Presents a beat at a falling edge once ready, leaves just after the
    // accepting rising edge with garbage on the data inputs.
    task automatic send_beat(input logic [AW-1:0] a, input logic [BW-1:0] b,
                             input logic last, output bit ok);
        int waited = 0;
        @(negedge clk);
        while (!pre_ready_u && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        ok = pre_ready_u;
        if (!ok) return;
        if (!in_job) model_clear();
        in_job = 1'b1;
        model_beat(a, b);
        a_vec = a; b_vec = b; pre_last = last; pre_valid = 1'b1;
        @(posedge clk);
        #1;
        pre_valid = 1'b0;
        a_vec = rand_a(0); b_vec = rand_b(0); pre_last = 1'($urandom);
    endtask

    // Cycles from now until o_post_valid is seen; -1 if it never comes.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (post_valid_u) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic consume();
        post_ready = 1'b1;
        @(posedge clk);
        #1;
        post_ready = 1'b0;
        in_job = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; pre_valid = 1'b1; a_vec = rand_a(0); b_vec = rand_b(0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; pre_valid = 1'b0;
        checks++;
        if ({post_valid_u, post_valid_s} !== 2'b00) begin
            errors++; $display("FAIL reset_post_valid got=%b want=00", {post_valid_u, post_valid_s});
        end
        checks++;
        if ({pre_ready_u, pre_ready_s} !== 2'b11) begin
            errors++; $display("FAIL reset_pre_ready got=%b want=11", {pre_ready_u, pre_ready_s});
        end
        checks++;
        if (c_u !== '0 || c_s !== '0 || {sat_u, sat_s} !== 2'b00) begin
            errors++; $display("FAIL reset_acc got=%h/%h sat=%b want=0", c_u, c_s, {sat_u, sat_s});
        end
        @(posedge clk);
        #1;
        checks++;
        if (pre_ready_u !== 1'b1) begin
            errors++; $display("FAIL reset_beat_ignored pre_ready got=%b want=1", pre_ready_u);
        end
        in_job = 1'b0;
    endtask

    task automatic test_directed();
        bit ok;
        int lat;
        logic [CW-1:0] want;
        want = {16'd276, 16'd240, 16'd204};
        send_beat(dir_a(), dir_b(), 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL dir_accept got=timeout want=accepted"); end
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if ({pre_ready_u, pre_ready_s, post_valid_u} !== 3'b000) begin
            errors++; $display("FAIL dir_mac_flags got=%b want=000", {pre_ready_u, pre_ready_s, post_valid_u});
        end
        wait_valid(lat);
        checks++;
        if (lat != K_TILE - 4) begin
            errors++; $display("FAIL dir_latency got=%0d want=%0d", lat + 4, K_TILE);
        end
        checks++;
        if (c_u !== want || c_s !== want) begin
            errors++; $display("FAIL dir_result got=%h/%h want=%h", c_u, c_s, want);
        end
        checks++;
        if ({sat_u, sat_s, post_valid_s} !== 3'b001) begin
            errors++; $display("FAIL dir_sat got=%b want=001", {sat_u, sat_s, post_valid_s});
        end
        consume();
        checks++;
        if ({post_valid_u, pre_ready_u} !== 2'b01) begin
            errors++; $display("FAIL dir_release got=%b want=01", {post_valid_u, pre_ready_u});
        end
    endtask

    task automatic test_two_beats();
        bit ok;
        int lat;
        logic [CW-1:0] want;
        want = {16'd552, 16'd480, 16'd408};
        send_beat(dir_a(), dir_b(), 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL two_accept1 got=timeout want=accepted"); end
        repeat (K_TILE - 1) begin @(posedge clk); #1; end
        checks++;
        if (pre_ready_u !== 1'b0) begin
            errors++; $display("FAIL two_mac_ready got=%b want=0", pre_ready_u);
        end
        @(posedge clk); #1;
        checks++;
        if ({pre_ready_u, post_valid_u} !== 2'b10) begin
            errors++; $display("FAIL two_wait_entry got=%b want=10", {pre_ready_u, post_valid_u});
        end
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if ({pre_ready_u, pre_ready_s, post_valid_u} !== 3'b110) begin
            errors++; $display("FAIL two_wait_hold got=%b want=110", {pre_ready_u, pre_ready_s, post_valid_u});
        end
        send_beat(dir_a(), dir_b(), 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL two_accept2 got=timeout want=accepted"); end
        wait_valid(lat);
        checks++;
        if (lat != K_TILE) begin errors++; $display("FAIL two_latency got=%0d want=%0d", lat, K_TILE); end
        checks++;
        if (c_u !== want || c_s !== want || {sat_u, sat_s} !== 2'b00) begin
            errors++; $display("FAIL two_result got=%h/%h sat=%b want=%h sat=00", c_u, c_s, {sat_u, sat_s}, want);
        end
        consume();
    endtask

    task automatic test_saturation();
        bit ok;
        int lat;
        logic [7:0] pats [3];
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        pats[0] = 8'h80; pats[1] = 8'hFF; pats[2] = 8'h00;
        for (int p = 0; p < 3; p++) begin
            a = {(ROWS*K_TILE){pats[p]}};
            b = {(COLS*K_TILE){pats[p]}};
            send_beat(a, b, 1'b1, ok);
            wait_valid(lat);
            checks++;
            if (!ok || lat != K_TILE) begin
                errors++; $display("FAIL sat_latency pat=%h got=%0d want=%0d", pats[p], lat, K_TILE);
            end
            checks++;
            if (c_u !== exp_vec(0) || sat_u !== rsat_u) begin
                errors++; $display("FAIL sat_unsigned pat=%h got=%h/%b want=%h/%b", pats[p], c_u, sat_u, exp_vec(0), rsat_u);
            end
            checks++;
            if (c_s !== exp_vec(1) || sat_s !== rsat_s) begin
                errors++; $display("FAIL sat_signed pat=%h got=%h/%b want=%h/%b", pats[p], c_s, sat_s, exp_vec(1), rsat_s);
            end
            if (p == 0) begin
                checks++;
                if (c_s !== {(ROWS*COLS){16'h7FFF}} || sat_s !== 1'b1) begin
                    errors++; $display("FAIL sat_signed_clip got=%h/%b want=7fff../1", c_s, sat_s);
                end
            end else if (p == 1) begin
                checks++;
                if (c_u !== {(ROWS*COLS){16'hFFFF}} || sat_u !== 1'b1) begin
                    errors++; $display("FAIL sat_unsigned_clip got=%h/%b want=ffff../1", c_u, sat_u);
                end
            end else begin
                checks++;
                if (c_u !== '0 || {sat_u, sat_s} !== 2'b00) begin
                    errors++; $display("FAIL sat_clear got=%h sat=%b want=0/00", c_u, {sat_u, sat_s});
                end
            end
            consume();
        end
    endtask

    task automatic test_hold();
        bit ok;
        int lat;
        int bad = 0;
        send_beat(rand_a(0), rand_b(0), 1'b1, ok);
        wait_valid(lat);
        checks++;
        if (!ok || lat != K_TILE) begin errors++; $display("FAIL hold_latency got=%0d want=%0d", lat, K_TILE); end
        pre_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_vec = rand_a(0); b_vec = rand_b(0);
            @(posedge clk); #1;
            checks++;
            if (post_valid_u !== 1'b1 || pre_ready_u !== 1'b0 || c_u !== exp_vec(0) ||
                c_s !== exp_vec(1) || sat_u !== rsat_u || sat_s !== rsat_s) begin
                errors++; bad++;
                if (bad < 4)
                    $display("FAIL hold_stable cyc=%0d got=v%b r%b %h/%h want=v1 r0 %h/%h",
                             i, post_valid_u, pre_ready_u, c_u, c_s, exp_vec(0), exp_vec(1));
            end
        end
        post_ready = 1'b1;
        @(posedge clk); #1;
        post_ready = 1'b0; pre_valid = 1'b0; in_job = 1'b0;
        checks++;
        if ({post_valid_u, pre_ready_u, post_valid_s, pre_ready_s} !== 4'b0101) begin
            errors++; $display("FAIL hold_release got=%b want=0101", {post_valid_u, pre_ready_u, post_valid_s, pre_ready_s});
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        logic [CW-1:0] want;
        want = {16'd276, 16'd240, 16'd204};
        send_beat(rand_a(0), rand_b(0), 1'b1, ok);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1; pre_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; pre_valid = 1'b0; in_job = 1'b0;
        checks++;
        if ({post_valid_u, pre_ready_u, sat_u, sat_s} !== 4'b0100 || c_u !== '0 || c_s !== '0) begin
            errors++; $display("FAIL rstmid_state got=%b %h/%h want=0100 0", {post_valid_u, pre_ready_u, sat_u, sat_s}, c_u, c_s);
        end
        @(posedge clk); #1;
        checks++;
        if (pre_ready_u !== 1'b1) begin
            errors++; $display("FAIL rstmid_no_accept pre_ready got=%b want=1", pre_ready_u);
        end
        send_beat(dir_a(), dir_b(), 1'b1, ok);
        wait_valid(lat);
        checks++;
        if (!ok || lat != K_TILE || c_u !== want || c_s !== want) begin
            errors++; $display("FAIL rstmid_rerun lat=%0d got=%h/%h want=%h", lat, c_u, c_s, want);
        end
        consume();
    endtask

    task automatic test_random_jobs();
        bit ok;
        int lat;
        int nb;
        int mode;
        for (int j = 0; j < 12; j++) begin
            nb   = int'($urandom_range(1, 3));
            mode = int'($urandom_range(0, 2));
            for (int bt = 0; bt < nb; bt++) begin
                send_beat(rand_a(mode), rand_b(mode), 1'(bt == nb - 1), ok);
                checks++;
                if (!ok) begin errors++; $display("FAIL rand_accept job=%0d got=timeout want=accepted", j); end
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            // consumer ready early has no effect before DONE
            post_ready = 1'(j % 2);
            wait_valid(lat);
            checks++;
            if (lat < 0 || lat > K_TILE) begin
                errors++; $display("FAIL rand_latency job=%0d got=%0d want<=%0d", j, lat, K_TILE);
            end
            checks++;
            if (c_u !== exp_vec(0) || sat_u !== rsat_u) begin
                errors++; $display("FAIL rand_unsigned job=%0d got=%h/%b want=%h/%b", j, c_u, sat_u, exp_vec(0), rsat_u);
            end
            checks++;
            if (c_s !== exp_vec(1) || sat_s !== rsat_s) begin
                errors++; $display("FAIL rand_signed job=%0d got=%h/%b want=%h/%b", j, c_s, sat_s, exp_vec(1), rsat_s);
            end
            repeat ($urandom_range(0, 3) * (1 - (j % 2))) begin @(posedge clk); #1; end
            consume();
            checks++;
            if ({post_valid_u, post_valid_s} !== 2'b00) begin
                errors++; $display("FAIL rand_release job=%0d got=%b want=00", j, {post_valid_u, post_valid_s});
            end
        end
    endtask

    initial begin
        rst = 1'b1; pre_valid = 1'b0; pre_last = 1'b0; post_ready = 1'b0;
        a_vec = '0; b_vec = '0; in_job = 1'b0;
        model_clear();
        test_reset();
        test_directed();
        test_two_beats();
        test_saturation();
        test_hold();
        test_reset_mid();
        test_random_jobs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matu_acc.md
MATU_ACC -- requirements
Module: matu_acc

Interface
REQ-001 SHALL have parameter ROWS, default 3: rows of A, one output element per row per B vector.
REQ-002 SHALL have parameter COLS, default 1: rows of B (output vectors).
REQ-003 SHALL have parameter K_TILE, default 9: reduction elements per input beat.
REQ-004 SHALL have parameter IN_WIDTH, default 8: operand width.
REQ-005 SHALL have parameter C_WIDTH, default 16: accumulator/result width; legal only if C_WIDTH >= 2*IN_WIDTH.
REQ-006 SHALL have parameter SIGNED, default 0: 1 = two's-complement operands/results, 0 = unsigned.
REQ-007 SHALL have one clock and a synchronous, active-high reset.
REQ-008 i_clk  in  1  clock; all state changes on rising edge.
REQ-009 i_rst  in  1  synchronous active-high reset.
REQ-010 i_pre_valid  in  1  input beat valid.
REQ-011 o_pre_ready  out  1  block accepts an input beat.
REQ-012 i_pre_last  in  1  beat is the final K-tile of the job; sampled with the beat.
REQ-013 i_a  in  [ROWS][K_TILE] x IN_WIDTH  A tile.
REQ-014 i_b  in  [COLS][K_TILE] x IN_WIDTH  B tile.
REQ-015 i_post_ready  in  1  consumer accepts the result.
REQ-016 o_post_valid  out  1  result valid.
REQ-017 o_c  out  [COLS][ROWS] x C_WIDTH  o_c[n][m] = sum over all beats and k of a[m][k]*b[n][k].
REQ-018 o_sat  out  1  sticky: at least one saturating add clipped during the current job.

Function
REQ-019 SHALL implement FSM states IDLE, MAC, WAIT, DONE.
REQ-020 Input handshake: beat accepted on an edge where i_pre_valid & o_pre_ready; o_pre_ready = 1 in IDLE and WAIT only, 0 in MAC and DONE.
REQ-021 On acceptance, i_a, i_b and i_pre_last SHALL be registered; the inputs may change on the following cycle.
REQ-022 Acceptance in IDLE SHALL clear all accumulators and o_sat (new job); acceptance in WAIT SHALL keep them (continue job).
REQ-023 Either acceptance SHALL move the FSM to MAC with k = 0.
REQ-024 MAC: each edge performs acc[n][m] <= sat(acc[n][m] + a[m][k]*b[n][k]) for all m,n in parallel, then k increments.
REQ-025 On the edge processing k = K_TILE-1: go to DONE if the registered last = 1, else go to WAIT.
REQ-026 Latency: o_post_valid SHALL go high exactly K_TILE cycles after the edge accepting the last beat.
REQ-027 Products SHALL be full 2*IN_WIDTH precision, sign- or zero-extended to C_WIDTH per SIGNED.
REQ-028 sat(): clamp to [-2^(C_WIDTH-1), 2^(C_WIDTH-1)-1] if SIGNED, else to [0, 2^C_WIDTH-1]; any clamp sets o_sat.
REQ-029 DONE: o_post_valid = 1; o_c and o_sat SHALL be held stable until i_post_ready = 1.
REQ-030 On an edge in DONE with i_post_ready = 1, go to IDLE; o_post_valid drops on the next cycle; no input is accepted on that edge.
REQ-031 o_c SHALL reflect the accumulators at all times; it is defined only while o_post_valid = 1.
REQ-032 i_pre_valid while o_pre_ready = 0 SHALL have no effect; i_post_ready outside DONE SHALL have no effect.
REQ-033 WAIT holds indefinitely with no timeout; accumulators are retained.

Reset
REQ-034 On i_rst = 1 at an edge, from any state including mid-MAC: FSM -> IDLE, k = 0, accumulators = 0, o_sat = 0, o_post_valid = 0, o_pre_ready = 1 from the next cycle.
REQ-035 A beat presented in the same cycle as i_rst SHALL NOT be accepted.
REQ-036 Reset priority SHALL be over all handshakes.

Verification
REQ-037 Defaults, single beat: a[m][k] = m+k, b[0][k] = k, last = 1 -> o_c[0] = {204, 240, 276}, o_sat = 0, o_post_valid 9 cycles after acceptance.
REQ-038 Same beat twice, last = 0 then last = 1 -> o_c[0] = {408, 480, 552}; o_pre_ready high only in WAIT between the beats.
REQ-039 SIGNED = 1, all a = b = -128, last = 1 -> o_c = 32767 for all elements (clips at k = 1), o_sat = 1.
REQ-040 SIGNED = 0, all a = b = 255 -> o_c = 65535 for all elements, o_sat = 1; a following job of zeros -> o_c = 0, o_sat = 0.
REQ-041 Hold i_post_ready = 0 for 20 cycles in DONE -> o_c, o_sat, o_post_valid stable and o_pre_ready = 0; release -> IDLE one cycle later.
REQ-042 Assert i_rst at k = 4 of MAC -> next cycle: IDLE, o_post_valid = 0, o_pre_ready = 1; the REQ-037 job run afterwards gives {204, 240, 276}.
